// File: rtl/periph_pkg.sv
// periph_pkg: shared defaults and arbiter state encoding for the peripheral buffer slice.
package periph_pkg;
    localparam int PERIPH_DATA_W = 16;
    localparam int PERIPH_NREQ = 4;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first requester found cyclically from ptr, optionally skipping one index.
module rr_priority_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         exclude_en,
    input  logic [W-1:0] exclude_idx,
    output logic         valid,
    output logic [W-1:0] idx
);
    int c;
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        idx = '0;
        c = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % N;
            if (req[c] && !(exclude_en && c == int'(exclude_idx))) begin
                valid = 1'b1;
                idx = W'(c);
            end
        end
    end
endmodule

// File: rtl/periph_buf_arbiter.sv
// periph_buf_arbiter: round-robin owner of the shared PeripheralBuffer register
// with bounded hold time and per-owner lock.
module periph_buf_arbiter
    import periph_pkg::*;
#(
    parameter int NREQ = PERIPH_NREQ,
    parameter int DATA_W = PERIPH_DATA_W,
    parameter int HOLD_MAX = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            lock,
    input  logic [NREQ-1:0]            wr_en,
    input  logic [NREQ*DATA_W-1:0]     wr_data,
    output logic [NREQ-1:0]            gnt,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    owner_id,
    output logic [DATA_W-1:0]          PeripheralBuffer
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int HOLD_W = $clog2(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    arb_state_t state;
    logic [IDX_W-1:0] rr_ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic leave;
    logic [IDX_W-1:0] next_ptr;
    rr_priority_pick #(.N(NREQ), .W(IDX_W)) u_pick (
        .req(req),
        .ptr(rr_ptr),
        .exclude_en(state == GRANT),
        .exclude_idx(owner_id),
        .valid(pick_valid),
        .idx(pick_idx)
    );
    // Release and preemption share one exit path.
    always_comb begin
        leave = !req[owner_id] || (!lock[owner_id] && hold_cnt == HOLD_LAST && pick_valid);
        next_ptr = (owner_id == IDX_W'(NREQ - 1)) ? '0 : owner_id + IDX_W'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            busy <= 1'b0;
            owner_id <= '0;
            PeripheralBuffer <= '0;
            rr_ptr <= '0;
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_valid) begin
                state <= GRANT;
                gnt <= NREQ'(1) << pick_idx;
                busy <= 1'b1;
                owner_id <= pick_idx;
                hold_cnt <= '0;
            end
        end else begin
            if (wr_en[owner_id])
                PeripheralBuffer <= wr_data[owner_id*DATA_W +: DATA_W];
            if (leave) begin
                rr_ptr <= next_ptr;
                hold_cnt <= '0;
                state <= pick_valid ? GRANT : IDLE;
                gnt <= pick_valid ? NREQ'(1) << pick_idx : '0;
                busy <= pick_valid;
                owner_id <= pick_valid ? pick_idx : '0;
            end else if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end
endmodule
